// File: rtl/ifu_if.sv
// Fetch-unit bundle: memory request/response channel, decode handshake,
// and execute-side redirect/halt controls. Signal suffixes are from the fetch unit's side.
interface ifu_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    logic              req_valid_o;
    logic              req_ready_i;
    logic [PC_W-1:0]   req_addr_o;
    logic              rsp_valid_i;
    logic [INST_W-1:0] rsp_data_i;
    logic              rsp_err_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [INST_W-1:0] inst_o;
    logic [PC_W-1:0]   pc_o;
    logic              fault_o;
    logic              redirect_valid_i;
    logic [PC_W-1:0]   redirect_pc_i;
    logic              halt_i;

    modport master (
        output req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, fault_o,
        input  req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i, inst_ready_i,
               redirect_valid_i, redirect_pc_i, halt_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, fault_o,
        output req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i, inst_ready_i,
               redirect_valid_i, redirect_pc_i, halt_i
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding 32-bit fetch, single-entry output
// buffer toward decode, execute redirects with stale-response kill, halt gating.
module ifu #(
    parameter int               PC_W     = 64,
    parameter int               INST_W   = 32,
    parameter logic [PC_W-1:0]  RESET_PC = 64'h8000_0000,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
    input logic   clock,
    input logic   reset,
    ifu_if.master bus
);
    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              kill_q, kill_d;
    logic              out_valid_q, out_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;
    logic              fault_q, fault_d;

    logic aligned;
    logic req_valid;
    logic req_fire;

    assign aligned   = (pc_q[1:0] == 2'b00);
    assign req_valid = (state_q == REQ) && !bus.halt_i && aligned;
    assign req_fire  = req_valid && bus.req_ready_i;

    assign bus.req_valid_o  = req_valid;
    assign bus.req_addr_o   = pc_q;
    // A redirect cycle must never look like a transfer to decode.
    assign bus.inst_valid_o = out_valid_q && !bus.redirect_valid_i;
    assign bus.inst_o       = inst_q;
    assign bus.pc_o         = pc_out_q;
    assign bus.fault_o      = fault_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        out_valid_d = out_valid_q;
        inst_d      = inst_q;
        pc_out_d    = pc_out_q;
        fault_d     = fault_q;

        case (state_q)
            BOOT: begin
                state_d = REQ;
                if (bus.redirect_valid_i) pc_d = bus.redirect_pc_i;
            end
            REQ: begin
                if (bus.redirect_valid_i) begin
                    pc_d = bus.redirect_pc_i;
                    if (req_fire) begin
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (req_fire) begin
                    kill_d  = 1'b0;
                    state_d = WAIT;
                end else if (!aligned && !bus.halt_i) begin
                    inst_d      = NOP_INST;
                    pc_out_d    = pc_q;
                    fault_d     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            WAIT: begin
                if (bus.redirect_valid_i) begin
                    pc_d = bus.redirect_pc_i;
                    if (bus.rsp_valid_i) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (bus.rsp_valid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d      = bus.rsp_err_i ? NOP_INST : bus.rsp_data_i;
                        fault_d     = bus.rsp_err_i;
                        pc_out_d    = pc_q;
                        pc_d        = pc_q + PC_W'(4);
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_valid_i) begin
                    out_valid_d = 1'b0;
                    pc_d        = bus.redirect_pc_i;
                    state_d     = REQ;
                end else if (bus.inst_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            pc_out_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            inst_q      <= inst_d;
            pc_out_q    <= pc_out_d;
            fault_q     <= fault_d;
        end
    end
endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: vector table for the sequential fetch stream plus scripted
// redirect/halt/fault/wrap/reset sequences; decode transfers are checked against a queue.
module tb_ifu;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clock = 1'b0;
    logic reset;

    ifu_if bus ();

    ifu dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          hold;
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    vec_t vecs[4];
    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_req(output logic [63:0] a, output int w);
        w = 0;
        a = '0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req_valid_o && bus.req_ready_i) begin
                a = bus.req_addr_o;
                cyc();
                return;
            end
            cyc();
            w++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL req_timeout: got no request in 50 cycles, expected one");
    endtask

    task automatic respond(input logic [31:0] d, input logic e);
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = d;
        bus.rsp_err_i   = e;
        cyc();
        bus.rsp_valid_i = 1'b0;
        bus.rsp_err_i   = 1'b0;
    endtask

    task automatic consume();
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.inst_valid_o) begin
                bus.inst_ready_i = 1'b1;
                cyc();
                bus.inst_ready_i = 1'b0;
                return;
            end
            cyc();
        end
        n_tests++;
        n_fail++;
        $display("FAIL inst_timeout: got no inst_valid_o in 50 cycles, expected one");
    endtask

    // Decode-side monitor, sampled just before the rising edge.
    always @(negedge clock) begin
        #4;
        if (bus.inst_valid_o === 1'b1 && bus.inst_ready_i === 1'b1) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_xfer: got pc %0h inst %0h, expected no transfer",
                         bus.pc_o, bus.inst_o);
            end else begin
                mon_e = sbq.pop_front();
                chk("xfer_pc", bus.pc_o, mon_e.pc);
                chk("xfer_inst", 64'(bus.inst_o), 64'(mon_e.inst));
                chk("xfer_fault", 64'(bus.fault_o), 64'(mon_e.fault));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int          w;

        vecs[0] = '{32'h0000_0513, 1'b0, 0, 0, 64'h8000_0000, 32'h0000_0513, 1'b0};
        vecs[1] = '{32'h0010_0073, 1'b0, 2, 5, 64'h8000_0004, 32'h0010_0073, 1'b0};
        vecs[2] = '{32'h1234_5678, 1'b1, 0, 2, 64'h8000_0008, 32'h0000_0013, 1'b1};
        vecs[3] = '{32'hCAFE_F00D, 1'b0, 1, 1, 64'h8000_000C, 32'hCAFE_F00D, 1'b0};

        reset                = 1'b1;
        bus.req_ready_i      = 1'b1;
        bus.rsp_valid_i      = 1'b0;
        bus.rsp_data_i       = '0;
        bus.rsp_err_i        = 1'b0;
        bus.inst_ready_i     = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.halt_i           = 1'b0;

        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_valid", 64'(bus.req_valid_o), 64'd0);
        chk("rst_inst_valid", 64'(bus.inst_valid_o), 64'd0);
        chk("rst_inst", 64'(bus.inst_o), 64'd0);
        chk("rst_pc_o", bus.pc_o, 64'd0);
        chk("rst_fault", 64'(bus.fault_o), 64'd0);
        chk("rst_addr", bus.req_addr_o, RESET_PC);

        reset = 1'b0;
        #1;
        chk("boot_req_valid", 64'(bus.req_valid_o), 64'd0);
        cyc();

        // Sequential stream from the vector table.
        for (int i = 0; i < 4; i++) begin
            wait_req(a, w);
            chk("tbl_addr", a, vecs[i].exp_pc);
            chk("tbl_req_gap", 64'(w), 64'd0);
            sbq.push_back('{vecs[i].exp_pc, vecs[i].exp_inst, vecs[i].exp_fault});
            for (int l = 0; l < vecs[i].lat; l++) begin
                #1;
                chk("wait_no_req", 64'(bus.req_valid_o), 64'd0);
                cyc();
            end
            respond(vecs[i].data, vecs[i].err);
            for (int h = 0; h < vecs[i].hold; h++) begin
                #1;
                chk("hold_valid", 64'(bus.inst_valid_o), 64'd1);
                chk("hold_no_req", 64'(bus.req_valid_o), 64'd0);
                chk("hold_inst", 64'(bus.inst_o), 64'(vecs[i].exp_inst));
                chk("hold_pc", bus.pc_o, vecs[i].exp_pc);
                cyc();
            end
            consume();
        end

        // Redirect in WAIT; late response must be dropped.
        wait_req(a, w);
        chk("a_addr", a, 64'h8000_0010);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 64'h8000_0100;
        cyc();
        bus.redirect_valid_i = 1'b0;
        cyc();
        cyc();
        respond(32'hDEAD_BEEF, 1'b0);
        wait_req(a, w);
        chk("a_redir_addr", a, 64'h8000_0100);
        chk("a_redir_gap", 64'(w), 64'd0);
        sbq.push_back('{64'h8000_0100, 32'h1111_1111, 1'b0});
        respond(32'h1111_1111, 1'b0);
        consume();

        // Redirect with request handshake, then redirect with response.
        #1;
        chk("b_req_valid", 64'(bus.req_valid_o), 64'd1);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 64'h8000_0200;
        cyc();
        bus.redirect_valid_i = 1'b0;
        respond(32'hBAD0_0001, 1'b0);
        wait_req(a, w);
        chk("b_hs_addr", a, 64'h8000_0200);
        chk("b_hs_gap", 64'(w), 64'd0);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 64'h8000_0300;
        respond(32'hBAD0_0002, 1'b0);
        bus.redirect_valid_i = 1'b0;
        wait_req(a, w);
        chk("b_rsp_addr", a, 64'h8000_0300);
        chk("b_rsp_gap", 64'(w), 64'd0);
        sbq.push_back('{64'h8000_0300, 32'h2222_2222, 1'b0});
        respond(32'h2222_2222, 1'b0);
        consume();

        // Halt gating, redirect while halted, misaligned target fault.
        bus.halt_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("halt_no_req", 64'(bus.req_valid_o), 64'd0);
            cyc();
        end
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 64'h8000_0102;
        cyc();
        bus.redirect_valid_i = 1'b0;
        #1;
        chk("c_addr", bus.req_addr_o, 64'h8000_0102);
        chk("c_halt_no_fault", 64'(bus.inst_valid_o), 64'd0);
        bus.halt_i = 1'b0;
        sbq.push_back('{64'h8000_0102, 32'h0000_0013, 1'b1});
        #1;
        chk("c_misalign_no_req", 64'(bus.req_valid_o), 64'd0);
        cyc();
        #1;
        chk("c_fault_valid", 64'(bus.inst_valid_o), 64'd1);
        chk("c_fault", 64'(bus.fault_o), 64'd1);
        consume();

        // PC wrap.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        bus.redirect_valid_i = 1'b0;
        wait_req(a, w);
        chk("wrap_top_addr", a, 64'hFFFF_FFFF_FFFF_FFFC);
        sbq.push_back('{64'hFFFF_FFFF_FFFF_FFFC, 32'h3333_3333, 1'b0});
        respond(32'h3333_3333, 1'b0);
        consume();
        wait_req(a, w);
        chk("wrap_zero_addr", a, 64'd0);
        chk("wrap_gap", 64'(w), 64'd0);
        sbq.push_back('{64'd0, 32'h4444_4444, 1'b0});
        respond(32'h4444_4444, 1'b0);
        consume();

        // Redirect in HOLD with ready high: no transfer.
        wait_req(a, w);
        chk("d_addr", a, 64'd4);
        respond(32'h5555_5555, 1'b0);
        #1;
        chk("d_hold_valid", 64'(bus.inst_valid_o), 64'd1);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 64'h8000_0040;
        bus.inst_ready_i     = 1'b1;
        #1;
        chk("d_valid_masked", 64'(bus.inst_valid_o), 64'd0);
        cyc();
        bus.redirect_valid_i = 1'b0;
        bus.inst_ready_i     = 1'b0;
        wait_req(a, w);
        chk("d_redir_addr", a, 64'h8000_0040);
        chk("d_redir_gap", 64'(w), 64'd0);

        // Asynchronous reset while a fetch is outstanding.
        reset = 1'b1;
        #1;
        chk("e_rst_req_valid", 64'(bus.req_valid_o), 64'd0);
        chk("e_rst_addr", bus.req_addr_o, RESET_PC);
        chk("e_rst_inst_valid", 64'(bus.inst_valid_o), 64'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("e_boot_req_valid", 64'(bus.req_valid_o), 64'd0);
        cyc();
        wait_req(a, w);
        chk("e_addr", a, RESET_PC);
        chk("e_gap", 64'(w), 64'd0);
        sbq.push_back('{RESET_PC, 32'h6666_6666, 1'b0});
        respond(32'h6666_6666, 1'b0);
        consume();

        cyc();
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
